// File: rtl/ram_access_master_if.sv
// Bundle of the command, write-stream, read-stream and RAM-side signals of ram_access_master.
// The master modport is the controller's view; slave is the view of everything around it.
interface ram_access_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;

  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_valid;
  logic                  wdata_ready;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic                  rdata_last;

  logic                  busy;

  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    input  req_valid, req_we, req_addr, req_len,
    input  wdata, wdata_valid,
    input  rdata_ready,
    input  ram_dout,
    output req_ready, wdata_ready,
    output rdata, rdata_valid, rdata_last,
    output busy,
    output ram_cs, ram_we, ram_oe, ram_addr, ram_din
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len,
    output wdata, wdata_valid,
    output rdata_ready,
    output ram_dout,
    input  req_ready, wdata_ready,
    input  rdata, rdata_valid, rdata_last,
    input  busy,
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_access_master.sv
// Burst controller for the single-port synchronous RAM: takes read/write burst commands,
// streams write beats into the RAM and returns read beats on a ready/valid stream.
module ram_access_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_access_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    RD_RESP
  } state_t;

  state_t                state;
  state_t                next_state;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;
  logic                  rdata_last_q;

  logic                  last_beat;
  logic                  rd_handshake;

  assign last_beat    = (beat_cnt == len_q);
  assign rd_handshake = rdata_valid_q && bus.rdata_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A read beat walks RD_ADDR -> RD_DATA -> RD_RESP, so each beat costs at least three cycles.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          next_state = bus.req_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (bus.wdata_valid && last_beat) begin
          next_state = IDLE;
        end
      end
      RD_ADDR: begin
        next_state = RD_DATA;
      end
      RD_DATA: begin
        next_state = RD_RESP;
      end
      RD_RESP: begin
        if (rd_handshake) begin
          next_state = last_beat ? IDLE : RD_ADDR;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr      <= '0;
      beat_cnt      <= '0;
      len_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cur_addr <= bus.req_addr;
            len_q    <= bus.req_len;
            beat_cnt <= '0;
          end
        end
        WR: begin
          if (bus.wdata_valid && !last_beat) begin
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
          end
        end
        RD_DATA: begin
          rdata_q       <= bus.ram_dout;
          rdata_valid_q <= 1'b1;
          rdata_last_q  <= last_beat;
        end
        RD_RESP: begin
          if (rd_handshake) begin
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            if (!last_beat) begin
              cur_addr <= cur_addr + ADDR_WIDTH'(1);
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Chip select follows wdata_valid in WR so that a gap cycle never writes the RAM.
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.busy        = (state != IDLE);
    bus.ram_cs      = 1'b0;
    bus.ram_we      = 1'b0;
    bus.ram_oe      = 1'b0;
    bus.ram_addr    = '0;
    bus.ram_din     = '0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
      end
      WR: begin
        bus.wdata_ready = 1'b1;
        bus.ram_cs      = bus.wdata_valid;
        bus.ram_we      = bus.wdata_valid;
        bus.ram_addr    = cur_addr;
        bus.ram_din     = bus.wdata;
      end
      RD_ADDR, RD_DATA: begin
        bus.ram_cs   = 1'b1;
        bus.ram_oe   = 1'b1;
        bus.ram_addr = cur_addr;
      end
      RD_RESP: begin
      end
      default: begin
      end
    endcase
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata_last  = rdata_last_q;

endmodule

// File: tb/tb_ram_access_master.sv
// Self-checking bench for ram_access_master: cycle-by-cycle vector table plus hand-written
// sequences for read backpressure, a command arriving while busy, and reset mid-read.
module tb_ram_access_master;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ram_access_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(4)) bus ();

  ram_access_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered read, output only meaningful while cs && !we && oe.
  logic [7:0] mem [0:255];
  logic [7:0] ram_q;

  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_cs && !bus.ram_we) ram_q <= mem[bus.ram_addr];
  end

  assign bus.ram_dout = (bus.ram_cs && !bus.ram_we && bus.ram_oe) ? ram_q : 8'hEE;

  typedef struct {
    logic       req_valid;
    logic       req_we;
    logic [7:0] req_addr;
    logic [3:0] req_len;
    logic [7:0] wdata;
    logic       wdata_valid;
    logic       rdata_ready;
    logic       e_req_ready;
    logic       e_busy;
    logic       e_wdata_ready;
    logic       e_cs;
    logic       e_we;
    logic       e_oe;
    logic [7:0] e_addr;
    logic [7:0] e_din;
    logic       e_rv;
    logic [7:0] e_rdata;
    logic       e_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t r_idle(logic rv, logic rwe, logic [7:0] ra, logic [3:0] rl);
    vec_t v;
    v = '{default: 0};
    v.req_valid   = rv;
    v.req_we      = rwe;
    v.req_addr    = ra;
    v.req_len     = rl;
    v.e_req_ready = 1'b1;
    return v;
  endfunction

  function automatic vec_t r_wr(logic [7:0] wd, logic wv, logic [7:0] ea);
    vec_t v;
    v = '{default: 0};
    v.wdata         = wd;
    v.wdata_valid   = wv;
    v.e_busy        = 1'b1;
    v.e_wdata_ready = 1'b1;
    v.e_cs          = wv;
    v.e_we          = wv;
    v.e_addr        = ea;
    v.e_din         = wd;
    return v;
  endfunction

  function automatic vec_t r_rd(logic [7:0] ea);
    vec_t v;
    v = '{default: 0};
    v.rdata_ready = 1'b1;
    v.e_busy      = 1'b1;
    v.e_cs        = 1'b1;
    v.e_oe        = 1'b1;
    v.e_addr      = ea;
    return v;
  endfunction

  function automatic vec_t r_resp(logic [7:0] er, logic el);
    vec_t v;
    v = '{default: 0};
    v.rdata_ready = 1'b1;
    v.e_busy      = 1'b1;
    v.e_rv        = 1'b1;
    v.e_rdata     = er;
    v.e_last      = el;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.req_valid   = v.req_valid;
    bus.req_we      = v.req_we;
    bus.req_addr    = v.req_addr;
    bus.req_len     = v.req_len;
    bus.wdata       = v.wdata;
    bus.wdata_valid = v.wdata_valid;
    bus.rdata_ready = v.rdata_ready;
  endtask

  task automatic check_row(input vec_t v, input int i);
    check_output($sformatf("row%0d req_ready", i), bus.req_ready, v.e_req_ready);
    check_output($sformatf("row%0d busy", i), bus.busy, v.e_busy);
    check_output($sformatf("row%0d wdata_ready", i), bus.wdata_ready, v.e_wdata_ready);
    check_output($sformatf("row%0d ram_cs", i), bus.ram_cs, v.e_cs);
    check_output($sformatf("row%0d ram_we", i), bus.ram_we, v.e_we);
    check_output($sformatf("row%0d ram_oe", i), bus.ram_oe, v.e_oe);
    check_output($sformatf("row%0d rdata_valid", i), bus.rdata_valid, v.e_rv);
    if (v.e_cs) check_output($sformatf("row%0d ram_addr", i), bus.ram_addr, v.e_addr);
    if (v.e_we) check_output($sformatf("row%0d ram_din", i), bus.ram_din, v.e_din);
    if (v.e_rv) begin
      check_output($sformatf("row%0d rdata", i), bus.rdata, v.e_rdata);
      check_output($sformatf("row%0d rdata_last", i), bus.rdata_last, v.e_last);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, " req_ready"}, bus.req_ready, 1);
    check_output({tag, " busy"}, bus.busy, 0);
    check_output({tag, " ram_cs"}, bus.ram_cs, 0);
    check_output({tag, " ram_we"}, bus.ram_we, 0);
    check_output({tag, " ram_oe"}, bus.ram_oe, 0);
    check_output({tag, " ram_addr"}, bus.ram_addr, 0);
    check_output({tag, " ram_din"}, bus.ram_din, 0);
    check_output({tag, " rdata_valid"}, bus.rdata_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply_stimulus('{default: 0});

    // Single write then read, then a wrapping 4-beat write and read-back.
    vecs.push_back(r_idle(1, 1, 8'h10, 4'd0));
    vecs.push_back(r_wr(8'hA5, 1, 8'h10));
    vecs.push_back(r_idle(1, 0, 8'h10, 4'd0));
    vecs.push_back(r_rd(8'h10));
    vecs.push_back(r_rd(8'h10));
    vecs.push_back(r_resp(8'hA5, 1));
    vecs.push_back(r_idle(1, 1, 8'hFE, 4'd3));
    vecs.push_back(r_wr(8'h11, 1, 8'hFE));
    vecs.push_back(r_wr(8'h22, 1, 8'hFF));
    vecs.push_back(r_wr(8'h33, 1, 8'h00));
    vecs.push_back(r_wr(8'h44, 1, 8'h01));
    vecs.push_back(r_idle(1, 0, 8'hFE, 4'd3));
    vecs.push_back(r_rd(8'hFE));
    vecs.push_back(r_rd(8'hFE));
    vecs.push_back(r_resp(8'h11, 0));
    vecs.push_back(r_rd(8'hFF));
    vecs.push_back(r_rd(8'hFF));
    vecs.push_back(r_resp(8'h22, 0));
    vecs.push_back(r_rd(8'h00));
    vecs.push_back(r_rd(8'h00));
    vecs.push_back(r_resp(8'h33, 0));
    vecs.push_back(r_rd(8'h01));
    vecs.push_back(r_rd(8'h01));
    vecs.push_back(r_resp(8'h44, 1));
    // Write with gaps: valid pattern 1,0,0,1,1.
    vecs.push_back(r_idle(1, 1, 8'h40, 4'd2));
    vecs.push_back(r_wr(8'hB0, 1, 8'h40));
    vecs.push_back(r_wr(8'hFF, 0, 8'h41));
    vecs.push_back(r_wr(8'hFF, 0, 8'h41));
    vecs.push_back(r_wr(8'hB1, 1, 8'h41));
    vecs.push_back(r_wr(8'hB2, 1, 8'h42));
    vecs.push_back(r_idle(0, 0, 8'h00, 4'd0));

    #12;
    @(negedge clk);
    check_idle_outputs("reset");
    check_output("reset rdata", bus.rdata, 0);
    check_output("reset rdata_last", bus.rdata_last, 0);
    check_output("reset wdata_ready", bus.wdata_ready, 0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_row(vecs[i], i);
      next_cycle();
    end

    // Read backpressure: 2-beat read at 0x40, beat 0 stalled for five cycles.
    apply_stimulus('{default: 0});
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h40;
    bus.req_len   = 4'd1;
    next_cycle();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_output("bp b0 ram_addr", bus.ram_addr, 8'h40);
    next_cycle();
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output($sformatf("bp stall%0d rdata_valid", k), bus.rdata_valid, 1);
      check_output($sformatf("bp stall%0d rdata", k), bus.rdata, 8'hB0);
      check_output($sformatf("bp stall%0d rdata_last", k), bus.rdata_last, 0);
      check_output($sformatf("bp stall%0d ram_cs", k), bus.ram_cs, 0);
      next_cycle();
    end
    bus.rdata_ready = 1'b1;
    @(negedge clk);
    check_output("bp handshake rdata_valid", bus.rdata_valid, 1);
    check_output("bp handshake rdata", bus.rdata, 8'hB0);
    next_cycle();
    bus.rdata_ready = 1'b0;
    @(negedge clk);
    check_output("bp b1 ram_cs", bus.ram_cs, 1);
    check_output("bp b1 ram_addr", bus.ram_addr, 8'h41);
    check_output("bp b1 rdata_valid", bus.rdata_valid, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_output("bp b1 rdata", bus.rdata, 8'hB1);
    check_output("bp b1 rdata_last", bus.rdata_last, 1);
    bus.rdata_ready = 1'b1;
    next_cycle();
    bus.rdata_ready = 1'b0;
    @(negedge clk);
    check_output("bp end busy", bus.busy, 0);
    check_output("bp end rdata_valid", bus.rdata_valid, 0);

    // Command while busy: a read at 0x61 is presented during a write burst at 0x60.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h60;
    bus.req_len   = 4'd1;
    next_cycle();
    bus.req_we   = 1'b0;
    bus.req_addr = 8'h61;
    @(negedge clk);
    check_output("cwb gap req_ready", bus.req_ready, 0);
    check_output("cwb gap wdata_ready", bus.wdata_ready, 1);
    check_output("cwb gap ram_cs", bus.ram_cs, 0);
    next_cycle();
    bus.wdata       = 8'h5A;
    bus.wdata_valid = 1'b1;
    @(negedge clk);
    check_output("cwb w0 req_ready", bus.req_ready, 0);
    check_output("cwb w0 ram_we", bus.ram_we, 1);
    check_output("cwb w0 ram_addr", bus.ram_addr, 8'h60);
    next_cycle();
    bus.wdata = 8'h5B;
    @(negedge clk);
    check_output("cwb w1 ram_addr", bus.ram_addr, 8'h61);
    next_cycle();
    bus.wdata_valid = 1'b0;
    @(negedge clk);
    check_output("cwb idle req_ready", bus.req_ready, 1);
    check_output("cwb idle busy", bus.busy, 0);
    next_cycle();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_output("cwb rd ram_oe", bus.ram_oe, 1);
    check_output("cwb rd ram_addr", bus.ram_addr, 8'h61);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_output("cwb rd rdata_valid", bus.rdata_valid, 1);
    check_output("cwb rd rdata", bus.rdata, 8'h5B);
    check_output("cwb rd rdata_last", bus.rdata_last, 0);

    // Reset while beat 0 of the deferred read waits in RD_RESP.
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst async rdata_valid", bus.rdata_valid, 0);
    check_output("rst async busy", bus.busy, 0);
    check_output("rst async req_ready", bus.req_ready, 1);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst release");
    check_output("rst release rdata", bus.rdata, 0);
    next_cycle();

    // Writes committed before the reset are still in the RAM.
    bus.req_valid   = 1'b1;
    bus.req_addr    = 8'h60;
    bus.req_len     = 4'd0;
    bus.rdata_ready = 1'b1;
    next_cycle();
    bus.req_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_output("persist rdata_valid", bus.rdata_valid, 1);
    check_output("persist rdata", bus.rdata, 8'h5A);
    check_output("persist rdata_last", bus.rdata_last, 1);
    next_cycle();
    @(negedge clk);
    check_output("persist end busy", bus.busy, 0);
    check_output("persist end rdata_valid", bus.rdata_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
